// File: rtl/udma_i2s_rx_packer.sv
// -----------------------------------------------------------------------------
// udma_i2s_rx_packer
//
// Packs 8-, 16- or 32-bit I2S receive samples little-endian into full 32-bit
// words for a uDMA RX channel, so byte and halfword audio uses the full bus
// width. One instance per RX channel, single clock domain (clk_i).
//
// Optional feature: define I2S_RX_PACKER_FLUSH_EN to enable flush_i. When
// enabled, flush_i emits the partial word with unused upper lanes set to
// PAD_BYTE. Without the macro flush_i is ignored.
//
// Parameters:
//   PAD_BYTE    fill value for unused byte lanes of a flushed partial word
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   en_i        enable; low discards the partial word and blocks input
//   datasize_i  sample size: 00 byte, 01 halfword, 10/11 word
//   flush_i     emit partial word (only with I2S_RX_PACKER_FLUSH_EN)
//   data_i      right-aligned input sample
//   valid_i     input sample valid
//   ready_o     input ready (combinational)
//   data_o      packed output word
//   valid_o     packed output word valid
//   ready_i     downstream ready
//   datasize_o  constant 2'b10 (word transfers)
//   level_o     bytes currently held in the accumulator (0..3)
// -----------------------------------------------------------------------------
module udma_i2s_rx_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  datasize_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [1:0]  datasize_o,
    output logic [1:0]  level_o
);

    logic [23:0] r_acc;
    logic [1:0]  r_cnt;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_flush_pend;

    logic [2:0]  w_size;
    logic [31:0] w_sample;
    logic [2:0]  w_sum;
    logic        w_complete;
    logic        w_slot_free;
    logic        w_flush_req;
    logic        w_flush_pend;
    logic        w_ready;
    logic        w_accept;
    logic [31:0] w_keep_mask;
    logic [31:0] w_pad_fill;
    logic [31:0] w_merged;
    logic [31:0] w_flush_word;

    // Sample size in bytes and the sample with unused upper bits cleared.
    always_comb begin
        w_size   = 3'd4;
        w_sample = data_i;
        case (datasize_i)
            2'b00: begin
                w_size   = 3'd1;
                w_sample = {24'h0, data_i[7:0]};
            end
            2'b01: begin
                w_size   = 3'd2;
                w_sample = {16'h0, data_i[15:0]};
            end
            default: begin
                w_size   = 3'd4;
                w_sample = data_i;
            end
        endcase
    end

    // Per-lane masks: lanes below cnt hold valid accumulated bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_keep_mask[gi*8 +: 8] = (r_cnt > 2'(gi)) ? 8'hFF : 8'h00;
            assign w_pad_fill[gi*8 +: 8]  = PAD_BYTE;
        end
    endgenerate

    // Existing lanes kept, new sample shifted up to lane cnt. The same value
    // serves as the next accumulator (partial) or the output word (complete).
    assign w_merged     = ({8'h00, r_acc} & w_keep_mask) | (w_sample << {r_cnt, 3'b000});
    assign w_flush_word = ({8'h00, r_acc} & w_keep_mask) | (w_pad_fill & ~w_keep_mask);

    // cnt + S is at most 7, so bit 2 marks a completed word.
    assign w_sum      = {1'b0, r_cnt} + w_size;
    assign w_complete = w_sum[2];

    assign w_slot_free = !r_valid || ready_i;

`ifdef I2S_RX_PACKER_FLUSH_EN
    // A flush request takes effect in the cycle it is raised, so a sample
    // offered in that same cycle is held off until after the flush word.
    assign w_flush_req = en_i && flush_i && (r_cnt != 2'd0);
`else
    logic w_unused_flush;
    assign w_unused_flush = flush_i;
    assign w_flush_req    = 1'b0;
`endif

    assign w_flush_pend = r_flush_pend || w_flush_req;

    assign w_ready  = !rst_i && en_i && !w_flush_pend && w_slot_free;
    assign w_accept = valid_i && w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc        <= 24'h0;
            r_cnt        <= 2'd0;
            r_data       <= 32'h0;
            r_valid      <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            // Drain; a load below in the same cycle overrides this.
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            if (!en_i) begin
                r_cnt        <= 2'd0;
                r_flush_pend <= 1'b0;
            end else if (w_flush_pend) begin
                if (w_slot_free) begin
                    r_data       <= w_flush_word;
                    r_valid      <= 1'b1;
                    r_cnt        <= 2'd0;
                    r_flush_pend <= 1'b0;
                end else begin
                    r_flush_pend <= 1'b1;
                end
            end else if (w_accept) begin
                if (w_complete) begin
                    r_data  <= w_merged;
                    r_valid <= 1'b1;
                    r_cnt   <= 2'd0;
                end else begin
                    r_acc <= w_merged[23:0];
                    r_cnt <= w_sum[1:0];
                end
            end
        end
    end

    assign ready_o    = w_ready;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign level_o    = r_cnt;
    assign datasize_o = 2'b10;

endmodule

// File: doc/udma_i2s_rx_packer.md
# udma_i2s_rx_packer

Sample packer between an I2S receive channel's sample FIFO output and its uDMA RX channel. It accepts 8-, 16- or 32-bit samples on a valid/ready stream. It packs them little-endian into full 32-bit words so that byte and halfword audio uses the L2 bus at full width. One instance is used per RX channel, in the `sys_clk_i` domain.

## Interface
Parameters:
- PAD_BYTE, 8'h00, fill value for unused byte lanes of a flushed partial word.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  packer enable; low discards the partial word and blocks input.
- datasize_i  in  2  sample size: 00 = byte, 01 = halfword, 10/11 = word. Static while en_i = 1.
- flush_i  in  1  request to emit a partial word (see Configuration).
- data_i  in  32  input sample, right-aligned; upper unused bits are ignored.
- valid_i  in  1  input sample valid.
- ready_o  out  1  input ready.
- data_o  out  32  packed word to uDMA.
- valid_o  out  1  packed word valid.
- ready_i  in  1  uDMA ready.
- datasize_o  out  2  constant 2'b10 (word transfers).
- level_o  out  2  number of bytes held in the accumulator (0–3).

## Operation
- State: 24-bit accumulator `acc`, byte count `cnt` (0–3), output register with valid flag, `flush_pend` flag.
- Size S: 1, 2 or 4 bytes per `datasize_i`. Legal streams keep `cnt` a multiple of S; the packer never straddles words.
- Input handshake: a sample is accepted when valid_i && ready_o.
- ready_o = en_i && !flush_pend && (!valid_o || ready_i). It is combinational and low during reset.
- Accepted sample with cnt + S < 4:
  - the sample bytes are written to lanes cnt..cnt+S-1 of `acc`;
  - cnt += S.
- Accepted sample with cnt + S == 4:
  - output register ← {sample bytes, acc lanes 0..cnt-1};
  - valid_o = 1;
  - cnt = 0.
- Output handshake: valid_o && ready_i clears valid_o, unless a new word loads in the same cycle, in which case valid_o stays 1 with the new data.
- While valid_o = 1, data_o is held stable.
- en_i low: cnt ← 0 and flush_pend ← 0 on the next edge. A pending output word still drains.
- Reset values: cnt = 0, acc = 0, valid_o = 0, data_o = 0, flush_pend = 0, level_o = 0, datasize_o = 2'b10.

## Timing
- Latency from the completing input handshake (edge N) to valid_o = 1 is 1 cycle (visible after edge N).
- Throughput is 1 sample/cycle with ready_i held high. Word mode gives 1 word/cycle.
- Back-pressure: with valid_o = 1 and ready_i = 0, ready_o = 0. No sample is lost or overwritten.
- rst_i asserted mid-word: state returns to reset values on that edge, and the partial word is discarded.
- level_o is registered and equals cnt.

## Configuration
- I2S_RX_PACKER_FLUSH_EN defined:
  - flush_i high with cnt != 0 sets flush_pend, which forces ready_o low.
  - When the output slot is free (!valid_o or ready_i), data_o ← acc lanes 0..cnt-1 with upper lanes = PAD_BYTE, valid_o = 1, cnt = 0, flush_pend = 0.
  - flush_i with cnt == 0 is ignored.
  - flush_i and a completing sample in the same cycle: flush_pend blocks the sample that cycle. The flush executes first and the sample is accepted after.
- Not defined: flush_i is ignored, flush_pend is constant 0, and partial words are emitted only by completion or discarded by en_i low.

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44, ready_i = 1 → a single word 0x44332211, valid_o one cycle after the 4th handshake, level_o stepping 1, 2, 3, 0.
- Halfwords 0xAAAA, 0xBBBB, then 0xCCCC, 0xDDDD back-to-back → words 0xBBBBAAAA and 0xDDDDCCCC on consecutive output beats.
- Word stream 0x01020304 with ready_i low for 3 cycles → ready_o low for those cycles, data_o stable, word delivered once, no sample lost.
- Two bytes 0x5A, 0xA5, then en_i = 0 for 1 cycle, then 4 bytes 0x01..0x04 → only 0x04030201 is emitted; level_o = 0 after the disable.
- FLUSH_EN, PAD_BYTE = 8'hEE, bytes 0x10, 0x20, then flush_i → data_o = 0xEEEE2010, valid_o = 1, level_o = 0; without the macro → no output.
- rst_i for 1 cycle after 3 bytes, then 4 bytes 0xA1..0xA4 → single word 0xA4A3A2A1, all outputs at reset values during reset.
